// File: rtl/router_ctrl_if.sv
// Handshake bundle between the packet source, the FIFO bank and router_ctrl.
// The slave modport is the controller's view and the master modport is the environment's view.
interface router_ctrl_if;
  logic       pkt_valid;
  logic [1:0] data_in;
  logic       parity_done;
  logic       low_pkt_valid;
  logic [2:0] fifo_full;
  logic [2:0] fifo_empty;
  logic [2:0] read_enb;
  logic [2:0] write_enb;
  logic [2:0] soft_rst;
  logic [2:0] vld_out;
  logic       detect_add, lfd_state, ld_state, laf_state;
  logic       full_state, rst_int_reg, write_enb_reg, busy;

  modport slave (
    input  pkt_valid, data_in, parity_done, low_pkt_valid, fifo_full, fifo_empty, read_enb,
    output write_enb, soft_rst, vld_out, detect_add, lfd_state, ld_state, laf_state,
           full_state, rst_int_reg, write_enb_reg, busy
  );

  modport master (
    output pkt_valid, data_in, parity_done, low_pkt_valid, fifo_full, fifo_empty, read_enb,
    input  write_enb, soft_rst, vld_out, detect_add, lfd_state, ld_state, laf_state,
           full_state, rst_int_reg, write_enb_reg, busy
  );
endinterface

// File: rtl/router_ctrl.sv
// Three-port router controller: a packet FSM that steers writes into one FIFO,
// plus per-port idle timers that soft-reset a FIFO which nobody drains.
module router_ctrl #(
  parameter int TIMEOUT = 30
) (
  input logic          clk,
  input logic          rst,
  router_ctrl_if.slave bus
);
  localparam int NUM_PORTS = 3;

  typedef enum logic [2:0] {
    DECODE, LFD, LOAD_DATA, LOAD_PARITY, FULL_ST, LAF, WAIT_EMPTY, CHK_PAR
  } state_e;

  state_e         state_q, state_d;
  logic [1:0]     addr_q, addr_d;
  logic           detect_add_q, lfd_q, ld_q, laf_q, full_q, rst_int_q, wer_q, busy_q;
  logic [NUM_PORTS-1:0]      srst_q;
  logic [NUM_PORTS-1:0][4:0] cnt_q;
  logic           full_a, empty_a, srst_a;

  // addr 3 never names a port, so its per-port flags read as 0
  assign full_a  = (addr_q != 2'd3) && bus.fifo_full[addr_q];
  assign empty_a = (addr_q != 2'd3) && bus.fifo_empty[addr_q];
  assign srst_a  = (addr_q != 2'd3) && srst_q[addr_q];
  assign addr_d  = (state_q == DECODE && bus.pkt_valid) ? bus.data_in : addr_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      DECODE:      if (bus.pkt_valid && bus.data_in != 2'd3)
                     state_d = bus.fifo_empty[bus.data_in] ? LFD : WAIT_EMPTY;
      LFD:         state_d = LOAD_DATA;
      LOAD_DATA:   if (full_a)              state_d = FULL_ST;
                   else if (!bus.pkt_valid) state_d = LOAD_PARITY;
      FULL_ST:     if (!full_a) state_d = LAF;
      LAF:         if (bus.parity_done)        state_d = DECODE;
                   else if (bus.low_pkt_valid) state_d = LOAD_PARITY;
                   else                        state_d = LOAD_DATA;
      LOAD_PARITY: state_d = CHK_PAR;
      CHK_PAR:     state_d = full_a ? FULL_ST : DECODE;
      WAIT_EMPTY:  if (empty_a) state_d = LFD;
      default:     state_d = DECODE;
    endcase
    if (srst_a) state_d = DECODE;
  end

  // Decodes are registered from the next state so they line up with state_q
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= DECODE;
      addr_q       <= 2'd0;
      detect_add_q <= 1'b1;
      lfd_q        <= 1'b0;
      ld_q         <= 1'b0;
      laf_q        <= 1'b0;
      full_q       <= 1'b0;
      rst_int_q    <= 1'b0;
      wer_q        <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      detect_add_q <= (state_d == DECODE);
      lfd_q        <= (state_d == LFD);
      ld_q         <= (state_d == LOAD_DATA);
      laf_q        <= (state_d == LAF);
      full_q       <= (state_d == FULL_ST);
      rst_int_q    <= (state_d == CHK_PAR);
      wer_q        <= (state_d == LOAD_DATA) || (state_d == LOAD_PARITY) || (state_d == LAF);
      busy_q       <= (state_d != DECODE) && (state_d != LOAD_DATA);
    end
  end

  for (genvar k = 0; k < NUM_PORTS; k++) begin : g_port
    logic inc, hit;
    assign inc = bus.vld_out[k] && !bus.read_enb[k];
    assign hit = inc && (cnt_q[k] == 5'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_q[k]  <= 5'd0;
        srst_q[k] <= 1'b0;
      end else begin
        cnt_q[k]  <= (!inc || hit) ? 5'd0 : cnt_q[k] + 5'd1;
        srst_q[k] <= hit;
      end
    end
  end

  always_comb begin
    bus.write_enb = '0;
    if (addr_q != 2'd3) bus.write_enb[addr_q] = wer_q;
  end

  assign bus.vld_out       = ~bus.fifo_empty;
  assign bus.soft_rst      = srst_q;
  assign bus.detect_add    = detect_add_q;
  assign bus.lfd_state     = lfd_q;
  assign bus.ld_state      = ld_q;
  assign bus.laf_state     = laf_q;
  assign bus.full_state    = full_q;
  assign bus.rst_int_reg   = rst_int_q;
  assign bus.write_enb_reg = wer_q;
  assign bus.busy          = busy_q;
endmodule

// File: doc/router_ctrl.md
ROUTER_CTRL -- requirements
Module: router_ctrl

Interface
REQ-001 Parameter: TIMEOUT, default 30, consecutive unread cycles before a port's soft reset fires; legal range 2..31.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 pkt_valid  input  1  source packet byte valid.
REQ-005 data_in  input  2  header destination address; 2'b11 is invalid.
REQ-006 parity_done  input  1  parity byte captured by the register block.
REQ-007 low_pkt_valid  input  1  pkt_valid fell while the FIFO was full.
REQ-008 fifo_full  input  3  per-port FIFO full flags.
REQ-009 fifo_empty  input  3  per-port FIFO empty flags.
REQ-010 read_enb  input  3  per-port downstream read enables.
REQ-011 write_enb  output  3  one-hot FIFO write enable.
REQ-012 soft_rst  output  3  per-port FIFO soft reset pulses.
REQ-013 vld_out  output  3  per-port data-available flags.
REQ-014 detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg, write_enb_reg, busy  output  1 each  state decodes to the register block and source.

Function
REQ-015 The FSM SHALL have the states DECODE, LFD (load first data), LOAD_DATA, LOAD_PARITY, FULL_ST, LAF (load after full), WAIT_EMPTY and CHK_PAR.
- Address register addr: SHALL latch data_in when in DECODE with pkt_valid=1.
- Per-port flags below are indexed by addr.
REQ-016 DECODE SHALL transition as follows:
- pkt_valid & data_in!=3 & fifo_empty[data_in] -> LFD.
- pkt_valid & data_in!=3 & !fifo_empty[data_in] -> WAIT_EMPTY.
- Otherwise (including data_in=3) -> stay in DECODE.
REQ-017 LFD SHALL go to LOAD_DATA unconditionally after one cycle.
REQ-018 LOAD_DATA SHALL go:
- to FULL_ST if fifo_full[addr] (full has priority);
- else to LOAD_PARITY if !pkt_valid;
- else stay.
REQ-019 FULL_ST SHALL stay while fifo_full[addr] is high, then go to LAF.
REQ-020 LAF SHALL go:
- to DECODE if parity_done;
- else to LOAD_PARITY if low_pkt_valid;
- else to LOAD_DATA.
REQ-021 LOAD_PARITY SHALL go to CHK_PAR after one cycle.
REQ-022 CHK_PAR SHALL go to FULL_ST if fifo_full[addr], else to DECODE.
REQ-023 WAIT_EMPTY SHALL stay until fifo_empty[addr] is high, then go to LFD.
REQ-024 soft_rst[addr]=1 in any state SHALL force next state DECODE, overriding REQ-016..023.
REQ-025 Outputs SHALL be Moore decodes of the state:
- detect_add = DECODE.
- lfd_state = LFD.
- ld_state = LOAD_DATA.
- laf_state = LAF.
- full_state = FULL_ST.
- rst_int_reg = CHK_PAR.
- write_enb_reg = LOAD_DATA | LOAD_PARITY | LAF.
- busy = 1 in every state except DECODE and LOAD_DATA.
REQ-026 write_enb[addr] SHALL equal write_enb_reg; the other two bits SHALL be 0.
REQ-027 vld_out[k] SHALL equal ~fifo_empty[k], combinationally.
REQ-028 Each port k SHALL have a 5-bit timer with the following behaviour:
- Increments on every cycle with vld_out[k] & !read_enb[k].
- Clears to 0 on any cycle with read_enb[k] or !vld_out[k].
REQ-029 When the port-k timer equals TIMEOUT-1 and the increment condition holds:
- the next edge SHALL set soft_rst[k]=1 for exactly one cycle and clear the timer;
- soft_rst[k] therefore rises after TIMEOUT consecutive unread cycles.
REQ-030 The three timers SHALL run independently, and simultaneous soft_rst pulses SHALL be allowed.

Reset
REQ-031 While rst=1 the block SHALL hold the following values:
- state = DECODE, addr = 0, all timers = 0, soft_rst = 0, write_enb = 0;
- detect_add = 1, all other state decodes = 0, busy = 0.
REQ-032 Assertion of rst mid-packet SHALL abandon the packet with no further write_enb pulse.

Verification
REQ-033 The bench SHALL cover the normal path: header addr=1 with all FIFOs empty, 3 payload bytes, then pkt_valid low.
- Required state sequence: DECODE, LFD, LOAD_DATA x3, LOAD_PARITY, CHK_PAR, DECODE.
- write_enb=3'b010 throughout the write states; busy=0 only in DECODE and LOAD_DATA.
REQ-034 The bench SHALL cover full back-pressure: fifo_full[1] rises during LOAD_DATA for 4 cycles.
- Required: FULL_ST for 4 cycles with write_enb=0, then LAF.
- From LAF with low_pkt_valid=1 and parity_done=0: -> LOAD_PARITY.
REQ-035 The bench SHALL cover a busy destination: header addr=2 with fifo_empty[2]=0 for 5 cycles.
- Required: WAIT_EMPTY for 5 cycles with busy=1, then LFD.
REQ-036 The bench SHALL cover an invalid address: header data_in=3 with pkt_valid=1.
- Required: FSM stays in DECODE and write_enb stays 0.
REQ-037 The bench SHALL cover the timeout path: fifo_empty[0]=0 and read_enb[0]=0 for 30 cycles.
- Required: soft_rst[0] is a one-cycle pulse after cycle 30.
- A read_enb[0] pulse at cycle 29 SHALL restart the count with no pulse.
REQ-038 The bench SHALL cover reset mid-packet: rst asserted asynchronously in LOAD_DATA.
- Required: DECODE and write_enb=0 immediately, without waiting for a clock edge.
